// File: rtl/pwm_bank_ctrl.sv
// Byte-stream register controller and shared period scheduler for a bank of PWM channels.
// Decodes SPI command/data bytes into shadow registers that move to active at each period wrap.
module pwm_bank_ctrl #(
    parameter int NUM_CH = 7,
    parameter int CNT_W  = 15
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    input  logic                      frame_abort,
    output logic [7:0]                tx_data,
    output logic                      tx_load,
    output logic                      busy,
    output logic                      err,
    output logic [CNT_W-1:0]          counter,
    output logic                      period_wrap,
    output logic [NUM_CH*CNT_W-1:0]   pwm_duty,
    output logic [NUM_CH-1:0]         pwm_en
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WR_HI = 2'd1;
    localparam logic [1:0] S_WR_LO = 2'd2;
    localparam logic [1:0] S_RD_LO = 2'd3;

    localparam logic [1:0] SEL_DUTY = 2'd0;
    localparam logic [1:0] SEL_EN   = 2'd1;
    localparam logic [1:0] SEL_PER  = 2'd2;

    logic [1:0]       r_state;
    logic [2:0]       r_ch;
    logic [1:0]       r_sel;
    logic [7:0]       r_hi;
    logic [7:0]       r_tx_data;
    logic             r_tx_load;
    logic             r_err;
    logic [CNT_W-1:0] r_counter;
    logic [CNT_W-1:0] r_period_sh;
    logic [CNT_W-1:0] r_period_act;
    logic [CNT_W-1:0] r_duty_sh  [NUM_CH];
    logic [CNT_W-1:0] r_duty_act [NUM_CH];
    logic [NUM_CH-1:0] r_en_sh;
    logic [NUM_CH-1:0] r_en_act;

    logic             w_wrap;
    logic [2:0]       w_q_ch;
    logic [1:0]       w_q_sel;
    logic             w_q_bad;
    logic [15:0]      w_rd_val;
    logic [CNT_W-1:0] w_wr_dat;

    assign w_wrap   = (r_counter == r_period_act);
    assign w_wr_dat = CNT_W'({r_hi, rx_data});

    // In IDLE the query comes straight from the command byte; afterwards from the latched command.
    always_comb begin
        w_q_ch   = (r_state == S_IDLE) ? rx_data[4:2] : r_ch;
        w_q_sel  = (r_state == S_IDLE) ? rx_data[1:0] : r_sel;
        w_q_bad  = ((w_q_sel == SEL_DUTY) || (w_q_sel == SEL_EN)) &&
                   ({29'd0, w_q_ch} >= 32'(NUM_CH));
        w_rd_val = '0;
        case (w_q_sel)
            SEL_DUTY: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (w_q_ch == 3'(i)) w_rd_val = 16'(r_duty_sh[i]);
                end
            end
            SEL_EN: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (w_q_ch == 3'(i)) w_rd_val = {15'd0, r_en_sh[i]};
                end
            end
            SEL_PER: w_rd_val = 16'(r_period_sh);
            default: w_rd_val = {8'h00, 8'(r_en_act)};
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ch        <= '0;
            r_sel       <= '0;
            r_hi        <= '0;
            r_tx_data   <= '0;
            r_tx_load   <= 1'b0;
            r_err       <= 1'b0;
            r_period_sh <= '1;
            r_en_sh     <= '0;
            // NOTE: shadow duty registers are flops, not RAM, so they take a reset value like any other state.
            for (int i = 0; i < NUM_CH; i++) r_duty_sh[i] <= '0;
        end else begin
            r_tx_load <= 1'b0;
            r_err     <= 1'b0;
            if (frame_abort) begin
                r_state <= S_IDLE;
            end else if (rx_valid) begin
                case (r_state)
                    S_IDLE: begin
                        r_ch  <= rx_data[4:2];
                        r_sel <= rx_data[1:0];
                        r_err <= w_q_bad;
                        if (rx_data[7]) begin
                            r_state <= S_WR_HI;
                        end else begin
                            r_state   <= S_RD_LO;
                            r_tx_data <= w_rd_val[15:8];
                            r_tx_load <= 1'b1;
                        end
                    end
                    S_WR_HI: begin
                        r_hi    <= rx_data;
                        r_state <= S_WR_LO;
                    end
                    S_WR_LO: begin
                        r_state <= S_IDLE;
                        // Out-of-range channels match no loop index, so the write is dropped.
                        case (r_sel)
                            SEL_DUTY: begin
                                for (int i = 0; i < NUM_CH; i++) begin
                                    if (r_ch == 3'(i)) r_duty_sh[i] <= w_wr_dat;
                                end
                            end
                            SEL_EN: begin
                                for (int i = 0; i < NUM_CH; i++) begin
                                    if (r_ch == 3'(i)) r_en_sh[i] <= rx_data[0];
                                end
                            end
                            SEL_PER: r_period_sh <= w_wr_dat;
                            default: ;
                        endcase
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_tx_data <= w_rd_val[7:0];
                        r_tx_load <= 1'b1;
                    end
                endcase
            end
        end
    end

    // A commit landing on the wrap edge is seen here as the old shadow, by non-blocking semantics.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_counter    <= '0;
            r_period_act <= '1;
            r_en_act     <= '0;
            for (int i = 0; i < NUM_CH; i++) r_duty_act[i] <= '0;
        end else if (w_wrap) begin
            r_counter    <= '0;
            r_period_act <= r_period_sh;
            r_en_act     <= r_en_sh;
            for (int i = 0; i < NUM_CH; i++) r_duty_act[i] <= r_duty_sh[i];
        end else begin
            r_counter <= r_counter + CNT_W'(1);
        end
    end

    always_comb begin
        pwm_duty = '0;
        for (int i = 0; i < NUM_CH; i++) pwm_duty[i*CNT_W +: CNT_W] = r_duty_act[i];
    end

    assign pwm_en      = r_en_act;
    assign counter     = r_counter;
    assign period_wrap = w_wrap;
    assign tx_data     = r_tx_data;
    assign tx_load     = r_tx_load;
    assign err         = r_err;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_pwm_bank_ctrl.sv
// Directed bench for pwm_bank_ctrl: register access over the byte stream and period scheduling.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pwm_bank_ctrl;

    localparam int NUM_CH = 7;
    localparam int CNT_W  = 15;

    logic                    sys_clk;
    logic                    rst;
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic                    frame_abort;
    logic [7:0]              tx_data;
    logic                    tx_load;
    logic                    busy;
    logic                    err;
    logic [CNT_W-1:0]        counter;
    logic                    period_wrap;
    logic [NUM_CH*CNT_W-1:0] pwm_duty;
    logic [NUM_CH-1:0]       pwm_en;

    int total = 0;
    int bad   = 0;

    pwm_bank_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .sys_clk(sys_clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_abort(frame_abort), .tx_data(tx_data), .tx_load(tx_load), .busy(busy),
        .err(err), .counter(counter), .period_wrap(period_wrap),
        .pwm_duty(pwm_duty), .pwm_en(pwm_en)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Called at a falling edge; the byte is sampled at the next rising edge, returns at the falling edge after.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_wrap(input int limit, input string name);
        int n;
        n = 0;
        while (period_wrap !== 1'b1 && n < limit) begin
            @(negedge sys_clk);
            n++;
        end
        total++; if (period_wrap !== 1'b1) begin bad++; $display("FAIL %s: no period_wrap within %0d cycles", name, limit); end
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_data = 8'h80; rx_valid = 1'b1; frame_abort = 1'b0;
        repeat (3) @(negedge sys_clk);
        total++; if (counter !== 15'd0) begin bad++; $display("FAIL reset_counter: got %h expected %h", counter, 15'd0); end
        total++; if (pwm_en !== 7'd0) begin bad++; $display("FAIL reset_en: got %h expected %h", pwm_en, 7'd0); end
        total++; if (pwm_duty !== '0) begin bad++; $display("FAIL reset_duty: got %h expected 0", pwm_duty); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (tx_load !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_strobes: got load=%b err=%b expected 0 0", tx_load, err); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_txdata: got %h expected 00", tx_data); end
        total++; if (period_wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %b expected 0", period_wrap); end
        rx_valid = 1'b0;
        rst = 1'b0;
        @(negedge sys_clk);
        send_byte(8'h02);
        total++; if (tx_load !== 1'b1 || tx_data !== 8'h7F) begin bad++; $display("FAIL reset_period_hi: got load=%b data=%h expected 1 7f", tx_load, tx_data); end
        send_byte(8'h00);
        total++; if (tx_load !== 1'b1 || tx_data !== 8'hFF) begin bad++; $display("FAIL reset_period_lo: got load=%b data=%h expected 1 ff", tx_load, tx_data); end
    endtask

    task automatic test_period;
        int e;
        send_byte(8'h82); send_byte(8'h00); send_byte(8'h09);
        send_byte(8'h06);
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL period_rd_hi: got %h expected 00", tx_data); end
        send_byte(8'hAA);
        total++; if (tx_data !== 8'h09) begin bad++; $display("FAIL period_rd_lo: got %h expected 09", tx_data); end
        wait_wrap(33000, "period_first_wrap");
        total++; if (counter !== 15'h7FFF) begin bad++; $display("FAIL period_old_top: got %h expected 7fff", counter); end
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            e = k % 10;
            total++; if (counter !== 15'(e) || period_wrap !== (e == 9)) begin
                bad++; $display("FAIL period_cycle%0d: got cnt=%h wrap=%b expected cnt=%h wrap=%b", k, counter, period_wrap, 15'(e), (e == 9));
            end
        end
    endtask

    task automatic test_duty_en;
        send_byte(8'h81); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h80); send_byte(8'h12); send_byte(8'h34);
        total++; if (pwm_duty[14:0] !== 15'h0000) begin bad++; $display("FAIL duty_before_wrap: got %h expected 0000", pwm_duty[14:0]); end
        wait_wrap(20, "duty_wrap");
        total++; if (pwm_duty[14:0] !== 15'h0000) begin bad++; $display("FAIL duty_at_wrap: got %h expected 0000", pwm_duty[14:0]); end
        @(negedge sys_clk);
        total++; if (pwm_duty[14:0] !== 15'h1234) begin bad++; $display("FAIL duty_after_wrap: got %h expected 1234", pwm_duty[14:0]); end
        total++; if (pwm_en !== 7'b0000001) begin bad++; $display("FAIL en_after_wrap: got %b expected 0000001", pwm_en); end
    endtask

    task automatic test_commit_at_wrap;
        int n;
        send_byte(8'h88); send_byte(8'h00);
        n = 0;
        while (counter !== 15'd9 && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        total++; if (counter !== 15'd9) begin bad++; $display("FAIL align_wrap: got cnt=%h expected 0009", counter); end
        send_byte(8'h05);
        total++; if (pwm_duty[30 +: 15] !== 15'd0) begin bad++; $display("FAIL commit_wrap_old: got %h expected 0000", pwm_duty[30 +: 15]); end
        wait_wrap(20, "commit_next_wrap");
        @(negedge sys_clk);
        total++; if (pwm_duty[30 +: 15] !== 15'd5) begin bad++; $display("FAIL commit_wrap_new: got %h expected 0005", pwm_duty[30 +: 15]); end
    endtask

    task automatic test_read;
        send_byte(8'h84); send_byte(8'h0A); send_byte(8'hBC);
        send_byte(8'h04);
        total++; if (tx_load !== 1'b1 || tx_data !== 8'h0A || busy !== 1'b1) begin
            bad++; $display("FAIL read_hi: got load=%b data=%h busy=%b expected 1 0a 1", tx_load, tx_data, busy);
        end
        @(negedge sys_clk);
        total++; if (tx_load !== 1'b0 || tx_data !== 8'h0A) begin bad++; $display("FAIL read_hold: got load=%b data=%h expected 0 0a", tx_load, tx_data); end
        send_byte(8'hFF);
        total++; if (tx_load !== 1'b1 || tx_data !== 8'hBC || busy !== 1'b0) begin
            bad++; $display("FAIL read_lo: got load=%b data=%h busy=%b expected 1 bc 0", tx_load, tx_data, busy);
        end
        send_byte(8'h03);
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL status_hi: got %h expected 00", tx_data); end
        send_byte(8'h00);
        total++; if (tx_data !== 8'h01) begin bad++; $display("FAIL status_lo: got %h expected 01", tx_data); end
        send_byte(8'h01); send_byte(8'h00);
        total++; if (tx_data !== 8'h01) begin bad++; $display("FAIL en_read: got %h expected 01", tx_data); end
    endtask

    task automatic test_err;
        logic [NUM_CH*CNT_W-1:0] exp_duty;
        exp_duty = '0;
        exp_duty[0 +: 15]  = 15'h1234;
        exp_duty[15 +: 15] = 15'h0ABC;
        exp_duty[30 +: 15] = 15'h0005;
        send_byte(8'h9C);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_pulse: got %b expected 1", err); end
        send_byte(8'hFF);
        total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL err_once: got err=%b busy=%b expected 0 1", err, busy); end
        send_byte(8'hFF);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL err_idle: got busy=%b expected 0", busy); end
        send_byte(8'h1C);
        total++; if (err !== 1'b1 || tx_data !== 8'h00) begin bad++; $display("FAIL err_read_hi: got err=%b data=%h expected 1 00", err, tx_data); end
        send_byte(8'h00);
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL err_read_lo: got %h expected 00", tx_data); end
        send_byte(8'h83);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL status_write_err: got %b expected 0", err); end
        send_byte(8'hAA); send_byte(8'hBB);
        wait_wrap(20, "err_wrap");
        @(negedge sys_clk);
        total++; if (pwm_duty !== exp_duty) begin bad++; $display("FAIL err_duty_kept: got %h expected %h", pwm_duty, exp_duty); end
        total++; if (pwm_en !== 7'b0000001) begin bad++; $display("FAIL err_en_kept: got %b expected 0000001", pwm_en); end
    endtask

    task automatic test_abort;
        send_byte(8'h80); send_byte(8'h55);
        frame_abort = 1'b1;
        @(negedge sys_clk);
        frame_abort = 1'b0;
        total++; if (busy !== 1'b0 || tx_load !== 1'b0) begin bad++; $display("FAIL abort_idle: got busy=%b load=%b expected 0 0", busy, tx_load); end
        send_byte(8'h00);
        total++; if (tx_data !== 8'h12) begin bad++; $display("FAIL abort_keep_hi: got %h expected 12", tx_data); end
        send_byte(8'h00);
        total++; if (tx_data !== 8'h34) begin bad++; $display("FAIL abort_keep_lo: got %h expected 34", tx_data); end
        send_byte(8'h80);
        rx_data = 8'h99; rx_valid = 1'b1; frame_abort = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0; frame_abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_wins: got busy=%b expected 0", busy); end
        send_byte(8'h80); send_byte(8'h00); send_byte(8'h07);
        send_byte(8'h00);
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL after_abort_hi: got %h expected 00", tx_data); end
        send_byte(8'h00);
        total++; if (tx_data !== 8'h07) begin bad++; $display("FAIL after_abort_lo: got %h expected 07", tx_data); end
    endtask

    task automatic test_period_zero;
        send_byte(8'h82); send_byte(8'h00); send_byte(8'h00);
        wait_wrap(20, "zero_wrap");
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            total++; if (counter !== 15'd0 || period_wrap !== 1'b1) begin
                bad++; $display("FAIL zero_hold%0d: got cnt=%h wrap=%b expected 0000 1", k, counter, period_wrap);
            end
        end
        send_byte(8'h80); send_byte(8'h00); send_byte(8'h33);
        @(negedge sys_clk);
        total++; if (pwm_duty[14:0] !== 15'h0033) begin bad++; $display("FAIL zero_load: got %h expected 0033", pwm_duty[14:0]); end
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; frame_abort = 1'b0;
        @(negedge sys_clk);
        test_reset();
        test_period();
        test_duty_en();
        test_commit_at_wrap();
        test_read();
        test_err();
        test_abort();
        test_period_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
